// File: rtl/sum_display_driver.sv
// sum_display_driver
// Takes the {carry,sum} result of the 4-bit adder stage (an unsigned value
// from 0 to 31). It converts that value to two decimal digits with a
// sequential double-dabble converter. It then drives a time-multiplexed,
// active-low, 4-digit seven-segment display. Only digits 0 (ones) and
// 1 (tens) are ever lit. A zero tens digit is blanked.
//
// Build option: define DISP_HEX_EN to drop the decimal converter.
// The value is then shown as hex: ones = sum, and tens = carry ("1" or blank).
// With DISP_HEX_EN defined, busy is tied low and the digits follow the input
// two edges after it changes.
module sum_display_driver #(
  parameter int REFRESH_BITS = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] sum,
  input  logic       carry,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp,
  output logic       busy
);

  // Active-low segment pattern {g,f,e,d,c,b,a} for one digit code.
  function automatic logic [6:0] glyph(input logic [3:0] code);
    logic [6:0] g;
    case (code)
      4'h0:    g = 7'b1000000;
      4'h1:    g = 7'b1111001;
      4'h2:    g = 7'b0100100;
      4'h3:    g = 7'b0110000;
      4'h4:    g = 7'b0011001;
      4'h5:    g = 7'b0010010;
      4'h6:    g = 7'b0000010;
      4'h7:    g = 7'b1111000;
      4'h8:    g = 7'b0000000;
      4'h9:    g = 7'b0010000;
`ifdef DISP_HEX_EN
      4'hA:    g = 7'b0001000;
      4'hB:    g = 7'b0000011;
      4'hC:    g = 7'b1000110;
      4'hD:    g = 7'b0100001;
      4'hE:    g = 7'b0000110;
      4'hF:    g = 7'b0001110;
`endif
      default: g = 7'b1111111;
    endcase
    return g;
  endfunction

  // Double-dabble correction: any BCD nibble of 5 or more gets +3 before the
  // shift, so that it carries correctly into the next decade.
  function automatic logic [7:0] dabble_adjust(input logic [7:0] bcd);
    logic [7:0] r;
    r = bcd;
    if (r[3:0] >= 4'd5) r[3:0] = r[3:0] + 4'd3;
    if (r[7:4] >= 4'd5) r[7:4] = r[7:4] + 4'd3;
    return r;
  endfunction

  // ------------------------------------------------------------------
  // Shared state: input capture, scan counter, display digits
  // ------------------------------------------------------------------
  logic [4:0]              in_q,   in_d;
  logic [REFRESH_BITS-1:0] scan_q, scan_d;
  logic [3:0]              tens_q, tens_d;
  logic [3:0]              ones_q, ones_d;
  logic [3:0]              an_q,   an_d;
  logic [6:0]              seg_q,  seg_d;
  logic [1:0]              digit_idx;

  // Capture the adder result every clock and advance the free-running scan.
  always_comb begin
    in_d   = {carry, sum};
    scan_d = scan_q + REFRESH_BITS'(1);
  end

  // Input and scan counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      in_q   <= 5'd0;
      scan_q <= '0;
    end else begin
      in_q   <= in_d;
      scan_q <= scan_d;
    end
  end

`ifdef DISP_HEX_EN
  // ------------------------------------------------------------------
  // Hex path: digits are the captured input, split at the carry bit
  // ------------------------------------------------------------------

  // Tens is the carry alone, so it reads "1" or is blanked as zero.
  always_comb begin
    tens_d = {3'b000, in_q[4]};
    ones_d = in_q[3:0];
  end

  // Displayed digit registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      tens_q <= 4'd0;
      ones_q <= 4'd0;
    end else begin
      tens_q <= tens_d;
      ones_q <= ones_d;
    end
  end

  assign busy = 1'b0;

`else
  // ------------------------------------------------------------------
  // Decimal path: sequential double-dabble converter
  // ------------------------------------------------------------------
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t     state_q,    state_d;
  logic [4:0] conv_val_q, conv_val_d;
  logic [4:0] shreg_q,    shreg_d;
  logic [7:0] bcd_q,      bcd_d;
  logic [2:0] bit_cnt_q,  bit_cnt_d;

  // Next-state logic for the converter. A new conversion starts whenever the
  // captured input differs from the last value converted. An input change
  // during a conversion is therefore picked up on the next pass through IDLE.
  always_comb begin
    state_d    = state_q;
    conv_val_d = conv_val_q;
    shreg_d    = shreg_q;
    bcd_d      = bcd_q;
    bit_cnt_d  = bit_cnt_q;
    tens_d     = tens_q;
    ones_d     = ones_q;
    case (state_q)
      S_IDLE: begin
        if (in_q != conv_val_q) begin
          shreg_d    = in_q;
          conv_val_d = in_q;
          bcd_d      = 8'd0;
          bit_cnt_d  = 3'd0;
          state_d    = S_SHIFT;
        end
      end
      S_SHIFT: begin
        {bcd_d, shreg_d} = {dabble_adjust(bcd_q), shreg_q} << 1;
        bit_cnt_d        = bit_cnt_q + 3'd1;
        if (bit_cnt_q == 3'd4) state_d = S_DONE;
      end
      S_DONE: begin
        tens_d  = bcd_q[7:4];
        ones_d  = bcd_q[3:0];
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Converter registers. Reset abandons any conversion in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      conv_val_q <= 5'd0;
      shreg_q    <= 5'd0;
      bcd_q      <= 8'd0;
      bit_cnt_q  <= 3'd0;
      tens_q     <= 4'd0;
      ones_q     <= 4'd0;
    end else begin
      state_q    <= state_d;
      conv_val_q <= conv_val_d;
      shreg_q    <= shreg_d;
      bcd_q      <= bcd_d;
      bit_cnt_q  <= bit_cnt_d;
      tens_q     <= tens_d;
      ones_q     <= ones_d;
    end
  end

  assign busy = (state_q != S_IDLE);
`endif

  // ------------------------------------------------------------------
  // Display scan: select a digit from the top two scan counter bits
  // ------------------------------------------------------------------
  assign digit_idx = scan_q[REFRESH_BITS-1 -: 2];

  // Anode and segment pattern for the digit currently being scanned.
  always_comb begin
    an_d  = 4'b1111;
    seg_d = 7'b1111111;
    case (digit_idx)
      2'd0: begin
        an_d  = 4'b1110;
        seg_d = glyph(ones_q);
      end
      2'd1: begin
        if (tens_q != 4'd0) begin
          an_d  = 4'b1101;
          seg_d = glyph(tens_q);
        end
      end
      default: begin
        an_d  = 4'b1111;
        seg_d = 7'b1111111;
      end
    endcase
  end

  // Registered display drive. It lags the digit index by one clock.
  always_ff @(posedge clk) begin
    if (rst) begin
      an_q  <= 4'b1111;
      seg_q <= 7'b1111111;
    end else begin
      an_q  <= an_d;
      seg_q <= seg_d;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;
  assign dp  = 1'b1;

endmodule

// File: tb/tb_sum_display_driver.sv
// Testbench for sum_display_driver (REFRESH_BITS = 3).
// The stimulus process drives {carry,sum} values. For each value that should
// trigger a conversion, it queues the value and the edge that first samples it.
// The monitor runs on the falling edge. It checks every display sample against
// the digits the model says are showing. Each time busy falls, it pops the
// queue and updates those digits.
module tb_sum_display_driver;
  localparam int RB = 3;

  logic       clk   = 1'b0;
  logic       rst   = 1'b1;
  logic [3:0] sum   = 4'd0;
  logic       carry = 1'b0;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;
  logic       busy;

  sum_display_driver #(.REFRESH_BITS(RB)) dut (
    .clk  (clk),
    .rst  (rst),
    .sum  (sum),
    .carry(carry),
    .an   (an),
    .seg  (seg),
    .dp   (dp),
    .busy (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int exp_val_q[$];
  int exp_base_q[$];
  int edge_n = 0;
  int last_val = 0;
  logic final_req = 1'b0;
  logic final_done = 1'b0;

  function automatic logic [6:0] ref_glyph(input int d);
    case (d)
      0:  return 7'b1000000;
      1:  return 7'b1111001;
      2:  return 7'b0100100;
      3:  return 7'b0110000;
      4:  return 7'b0011001;
      5:  return 7'b0010010;
      6:  return 7'b0000010;
      7:  return 7'b1111000;
      8:  return 7'b0000000;
      9:  return 7'b0010000;
      10: return 7'b0001000;
      11: return 7'b0000011;
      12: return 7'b1000110;
      13: return 7'b0100001;
      14: return 7'b0000110;
      15: return 7'b0001110;
      default: return 7'b1111111;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s at edge %0d: got %0h expected %0h", name, edge_n, act, req);
    end
  endtask

  // Monitor / scoreboard
  initial begin : monitor
    int scan_ref, disp_val, in_m, busy_run, last_done;
    int slot, t, o, v, b, exp_done;
    logic busy_prev;
    scan_ref = 0; disp_val = 0; in_m = 0; busy_run = 0; last_done = -100;
    busy_prev = 1'b0;
    forever begin
      @(negedge clk);
      edge_n++;
      chk("dp", 32'(dp), 32'd1);
      if (rst) begin
        chk("rst_an", 32'(an), 32'hF);
        chk("rst_seg", 32'(seg), 32'h7F);
        chk("rst_busy", 32'(busy), 32'd0);
        scan_ref = 0; disp_val = 0; in_m = 0; busy_run = 0; last_done = -100;
        busy_prev = 1'b0;
        exp_val_q.delete();
        exp_base_q.delete();
      end else begin
        slot = (scan_ref / 2) % 4;
`ifdef DISP_HEX_EN
        t = disp_val / 16; o = disp_val % 16;
`else
        t = disp_val / 10; o = disp_val % 10;
`endif
        case (slot)
          0: begin
            chk("an_ones", 32'(an), 32'hE);
            chk("seg_ones", 32'(seg), 32'(ref_glyph(o)));
          end
          1: begin
            if (t != 0) begin
              chk("an_tens", 32'(an), 32'hD);
              chk("seg_tens", 32'(seg), 32'(ref_glyph(t)));
            end else begin
              chk("an_tens_blank", 32'(an), 32'hF);
            end
          end
          default: begin
            chk("an_off", 32'(an), 32'hF);
            chk("seg_off", 32'(seg), 32'h7F);
          end
        endcase
        scan_ref = (scan_ref + 1) % (1 << RB);
`ifdef DISP_HEX_EN
        chk("busy_hex", 32'(busy), 32'd0);
        disp_val = in_m;
        in_m = int'({carry, sum});
`else
        if (busy) begin
          busy_run++;
        end else if (busy_prev) begin
          chk("busy_len", 32'(busy_run), 32'd6);
          chk("pending_conv", 32'(exp_val_q.size() > 0), 32'd1);
          if (exp_val_q.size() > 0) begin
            v = exp_val_q.pop_front();
            b = exp_base_q.pop_front();
            exp_done = (b + 7 > last_done + 7) ? b + 7 : last_done + 7;
            chk("done_edge", 32'(edge_n), 32'(exp_done));
            disp_val = v;
          end
          last_done = edge_n;
          busy_run = 0;
        end
        busy_prev = busy;
`endif
        if (final_req && !final_done) begin
          chk("queue_empty", 32'(exp_val_q.size()), 32'd0);
          chk("busy_idle", 32'(busy), 32'd0);
          final_done = 1'b1;
        end
      end
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drive a new value just after a falling edge. If it differs from the last
  // value converted, queue it with the edge number that first samples it.
  task automatic drive(input int v);
    @(negedge clk);
    #1;
    {carry, sum} = 5'(v);
`ifndef DISP_HEX_EN
    if (v != last_val) begin
      exp_val_q.push_back(v);
      exp_base_q.push_back(edge_n + 1);
    end
`endif
    last_val = v;
  endtask

  // Stimulus
  initial begin : stimulus
    // Reset for two cycles with a zero input; display should read "0".
    wait_cyc(2);
    #1 rst = 1'b0;
    wait_cyc(14);

    drive(7);  wait_cyc(20);
    drive(31); wait_cyc(20);

    // Change 9 -> 12 two cycles after busy rises.
    drive(9);  wait_cyc(2);
    drive(12); wait_cyc(24);

    // Reset while shifting the value 25, then convert it again from scratch.
    drive(25); wait_cyc(2);
    @(negedge clk); #1 rst = 1'b1;
    @(negedge clk); #1 rst = 1'b0;
`ifndef DISP_HEX_EN
    exp_val_q.push_back(25);
    exp_base_q.push_back(edge_n + 1);
`endif
    wait_cyc(20);

    drive(27); wait_cyc(20);
    drive(16); wait_cyc(20);
    drive(10); wait_cyc(20);

    repeat (12) begin
      drive(int'($urandom_range(0, 31)));
      wait_cyc(int'($urandom_range(16, 24)));
    end

    wait_cyc(12);
    final_req = 1'b1;
    wait_cyc(3);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
